// File: rtl/width_conv_pkg.sv
// Shared types and helpers for the width downsizer.
// Lane order is selected at build time by WDC_MSB_FIRST_EN.
package width_conv_pkg;

  typedef enum logic {LSB_FIRST, MSB_FIRST} lane_order_e;

`ifdef WDC_MSB_FIRST_EN
  localparam lane_order_e LANE_ORDER = MSB_FIRST;
`else
  localparam lane_order_e LANE_ORDER = LSB_FIRST;
`endif

  typedef enum logic {IDLE, BUSY} ser_state_e;

  // Lane index needs at least one bit even for degenerate ratios.
  function automatic int lane_idx_width(input int ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/wdc_sync_fifo.sv
// Single-clock DEPTH x WIDTH register FIFO with occupancy count.
// Push is refused while full and pop while empty, even if both are requested together.
module wdc_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/width_downsizer.sv
// N:1 width downsizer: buffered wide words serialised into RATIO narrow lanes.
// Define WDC_MSB_FIRST_EN to emit the most-significant lane first.
module width_downsizer
  import width_conv_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int RATIO = 2,
  parameter int DEPTH = 4,
  localparam int IN_W  = RATIO * OUT_W,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int IDX_W = lane_idx_width(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  ser_state_e       state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [IN_W-1:0]  word_reg, word_next;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IN_W-1:0]  fifo_rd_data;
  logic [LVL_W-1:0] fifo_count;
  logic             lane_done;
  logic             word_done;
  logic [OUT_W-1:0] lanes [RATIO];

  wdc_sync_fifo #(
    .WIDTH (IN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data (s_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign s_ready   = !fifo_full;
  assign fifo_push = s_valid && s_ready;
  assign full      = fifo_full;
  assign level     = fifo_count;
  assign empty     = fifo_empty && (state_reg == IDLE);
  assign m_valid   = (state_reg == BUSY);
  assign lane_done = m_valid && m_ready;
  assign word_done = lane_done && (idx_reg == LAST_IDX);
  // Reloading on the last handshake keeps the output stream free of bubbles.
  assign fifo_pop  = !fifo_empty && ((state_reg == IDLE) || word_done);

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    if (LANE_ORDER == MSB_FIRST) begin : g_msb
      assign lanes[gi] = word_reg[(RATIO-1-gi)*OUT_W +: OUT_W];
    end else begin : g_lsb
      assign lanes[gi] = word_reg[gi*OUT_W +: OUT_W];
    end
  end

  assign m_data = m_valid ? lanes[idx_reg] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      word_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      word_reg  <= word_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    word_next  = word_reg;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = BUSY;
          idx_next   = '0;
          word_next  = fifo_rd_data;
        end
      end
      BUSY: begin
        if (word_done) begin
          idx_next = '0;
          if (!fifo_empty) begin
            word_next = fifo_rd_data;
          end else begin
            state_next = IDLE;
          end
        end else if (lane_done) begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_width_downsizer.sv
// Scoreboard bench for width_downsizer (OUT_W=8, RATIO=2, DEPTH=4).
// Lane expectations follow WDC_MSB_FIRST_EN when it is defined.
module tb_width_downsizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        full;
  logic        empty;
  logic [2:0]  level;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  bit          prev_stall = 0;
  logic [7:0]  prev_data = '0;
  bit          stream_on = 0;
  int          max_level = 0;

  width_downsizer #(.OUT_W(8), .RATIO(2), .DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  function automatic logic [7:0] lane_of(input logic [15:0] w, input int k);
`ifdef WDC_MSB_FIRST_EN
    return (k == 0) ? w[15:8] : w[7:0];
`else
    return (k == 0) ? w[7:0] : w[15:8];
`endif
  endfunction

  // Monitor: accepted words feed the scoreboard, handshaken lanes drain it.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) begin
          check("stall_valid", {31'd0, m_valid}, 32'd1);
          check("stall_data", {24'd0, m_data}, {24'd0, prev_data});
        end
        if (s_valid && s_ready) begin
          exp_q.push_back(lane_of(s_data, 0));
          exp_q.push_back(lane_of(s_data, 1));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_lane", {24'd0, m_data}, 32'hFFFF_FFFF);
          end else begin
            check("lane", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
          end
        end
        if (stream_on && int'(level) > max_level) max_level = int'(level);
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
      end else begin
        prev_stall = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called just after a rising edge; returns once the word is taken or the bound expires.
  task automatic push_word(input logic [15:0] d, input int max_wait, output bit ok);
    ok = 0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (s_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    m_ready = 1'b1;
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_empty"}, {31'd0, empty}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit ok;
    bit found;
    rst_n   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();

    // Single word: latency and lane order.
    m_ready = 1'b1;
    push_word(16'hA5B6, 4, ok);
    check("single_push", {31'd0, ok}, 32'd1);
    @(negedge clk);
    check("single_wait_valid", {31'd0, m_valid}, 32'd0);
    check("single_wait_level", {29'd0, level}, 32'd1);
    check("single_wait_empty", {31'd0, empty}, 32'd0);
    @(negedge clk);
    check("single_l0_valid", {31'd0, m_valid}, 32'd1);
    check("single_l0", {24'd0, m_data}, {24'd0, lane_of(16'hA5B6, 0)});
    @(negedge clk);
    check("single_l1", {24'd0, m_data}, {24'd0, lane_of(16'hA5B6, 1)});
    @(negedge clk);
    check("single_idle_valid", {31'd0, m_valid}, 32'd0);
    check("single_idle_empty", {31'd0, empty}, 32'd1);
    @(posedge clk);
    #1;

    // Fill with the consumer stalled: 1 serialising + 4 buffered.
    m_ready = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      push_word(16'(w), 3, ok);
      check("fill_push", {31'd0, ok}, 32'd1);
    end
    push_word(16'h0006, 3, ok);
    check("fill_refused", {31'd0, ok}, 32'd0);
    @(negedge clk);
    check("fill_level", {29'd0, level}, 32'd4);
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_s_ready", {31'd0, s_ready}, 32'd0);
    check("fill_m_valid", {31'd0, m_valid}, 32'd1);
    @(posedge clk);
    #1;
    drain("fill_drain", 40);

    // Random backpressure on two words.
    m_ready = 1'b0;
    push_word(16'h1122, 3, ok);
    check("bp_push0", {31'd0, ok}, 32'd1);
    push_word(16'h3344, 3, ok);
    check("bp_push1", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    drain("bp_drain", 20);

    // Streaming at one word per RATIO cycles: no output gaps.
    m_ready   = 1'b1;
    max_level = 0;
    stream_on = 1;
    fork
      begin
        for (int w = 0; w < 8; w++) begin
          push_word(16'hF000 + 16'(w * 16'h0101), 4, ok);
          check("stream_push", {31'd0, ok}, 32'd1);
          @(posedge clk);
          #1;
        end
      end
      begin
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
          @(negedge clk);
          if (m_valid) found = 1;
        end
        check("stream_start", {31'd0, found}, 32'd1);
        for (int k = 1; k < 16; k++) begin
          @(negedge clk);
          check("stream_gap", {31'd0, m_valid}, 32'd1);
        end
      end
    join
    stream_on = 0;
    check("stream_max_level", max_level, 1);
    drain("stream_drain", 20);

    // Reset after the first lane: the rest of the word must vanish.
    m_ready = 1'b0;
    push_word(16'hA5B6, 3, ok);
    check("mid_push", {31'd0, ok}, 32'd1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (m_valid) found = 1;
    end
    check("mid_valid", {31'd0, found}, 32'd1);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    check("mid_first_taken", exp_q.size(), 1);
    m_ready = 1'b0;
    apply_reset();
    m_ready = 1'b1;
    push_word(16'hC3D4, 3, ok);
    check("mid_push_after", {31'd0, ok}, 32'd1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (m_valid) found = 1;
    end
    check("mid_after_valid", {31'd0, found}, 32'd1);
    check("mid_after_l0", {24'd0, m_data}, {24'd0, lane_of(16'hC3D4, 0)});
    @(posedge clk);
    #1;
    drain("mid_drain", 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
